// File: rtl/sub16_nibble_serial_if.sv
// sub16_nibble_serial_if: operand/result handshake bundle for the serial subtractor.
// SUB_OVF_EN adds the signed-overflow flag.
interface sub16_nibble_serial_if #(parameter int DATA_W = 16);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              b_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] diff;
    logic              b_out;
`ifdef SUB_OVF_EN
    logic              ovf;
`endif
    modport master (
        output in_valid, a, b, b_in, out_ready,
        input  in_ready, out_valid, diff, b_out
`ifdef SUB_OVF_EN
        , input ovf
`endif
    );
    modport slave (
        input  in_valid, a, b, b_in, out_ready,
        output in_ready, out_valid, diff, b_out
`ifdef SUB_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/sub16_nibble_serial.sv
// sub16_nibble_serial: a - b - b_in computed one SLICE_W slice per clock, LSB first.
// SUB_OVF_EN adds a registered signed-overflow output.
module sub16_nibble_serial #(
    parameter int DATA_W  = 16,
    parameter int SLICE_W = 4
) (
    input logic                   clk,
    input logic                   rst,
    sub16_nibble_serial_if.slave  bus
);
    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t            state;
    logic [DATA_W-1:0] a_r, b_r, diff_r;
    logic [CW-1:0]     cnt;
    logic              borrow, b_out_r, in_ready_r, out_valid_r;
    logic [SLICE_W:0]  sub;
`ifdef SUB_OVF_EN
    logic              a_msb, b_msb, ovf_r;
    assign bus.ovf = ovf_r;
`endif
    // operands shift right each cycle, so the current slice is always the low slice
    assign sub = {1'b0, a_r[SLICE_W-1:0]} - {1'b0, b_r[SLICE_W-1:0]} - (SLICE_W+1)'(borrow);
    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.diff      = diff_r;
    assign bus.b_out     = b_out_r;
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            diff_r      <= '0;
            b_out_r     <= 1'b0;
            cnt         <= '0;
            borrow      <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
`ifdef SUB_OVF_EN
            a_msb       <= 1'b0;
            b_msb       <= 1'b0;
            ovf_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_r        <= bus.a;
                    b_r        <= bus.b;
                    borrow     <= bus.b_in;
                    cnt        <= '0;
                    in_ready_r <= 1'b0;
                    state      <= RUN;
`ifdef SUB_OVF_EN
                    a_msb      <= bus.a[DATA_W-1];
                    b_msb      <= bus.b[DATA_W-1];
`endif
                end
                RUN: begin
                    a_r    <= a_r >> SLICE_W;
                    b_r    <= b_r >> SLICE_W;
                    diff_r <= DATA_W'({sub[SLICE_W-1:0], diff_r} >> SLICE_W);
                    borrow <= sub[SLICE_W];
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(NSLICE - 1)) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                        b_out_r     <= sub[SLICE_W];
`ifdef SUB_OVF_EN
                        ovf_r       <= (a_msb ^ b_msb) & (a_msb ^ sub[SLICE_W-1]);
`endif
                    end
                end
                DONE: if (bus.out_ready) begin
                    state       <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sub16_nibble_serial.sv
// tb_sub16_nibble_serial: vector table plus handshake corner sequences,
// results checked from a scoreboard queue as the DUT retires them.
module tb_sub16_nibble_serial;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sub16_nibble_serial_if #(.DATA_W(16)) bus();
    sub16_nibble_serial #(.DATA_W(16), .SLICE_W(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] diff;
        logic        bo;
        logic        ovf;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[10];
    vec_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
        vec_t        v;
        logic [16:0] r;
        r      = {1'b0, a} - {1'b0, b} - 17'(bin);
        v.a    = a;
        v.b    = b;
        v.bin  = bin;
        v.diff = r[15:0];
        v.bo   = r[16];
        v.ovf  = (a[15] ^ b[15]) & (a[15] ^ r[15]);
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got diff=%h expected no result", bus.diff);
            end else begin
                mon_e = sb.pop_front();
                chk("diff", 32'(bus.diff), 32'(mon_e.diff));
                chk("b_out", 32'(bus.b_out), 32'(mon_e.bo));
`ifdef SUB_OVF_EN
                chk("ovf", 32'(bus.ovf), 32'(mon_e.ovf));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input vec_t v, input bit push);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got in_ready=0 expected 1");
        end
        bus.in_valid = 1'b1;
        bus.a        = v.a;
        bus.b        = v.b;
        bus.b_in     = v.bin;
        if (push) sb.push_back(v);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !bus.in_ready) && n < 50) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(n >= 50), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        int   accepts;
        int   last;
        bit   seen;
        vec_t v;
        tbl[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
        tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        tbl[2] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        tbl[4] = '{16'hFFFF, 16'h0F0F, 1'b0, 16'hF0F0, 1'b0, 1'b0};
        tbl[5] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[6] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        tbl[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        tbl[8] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};
        tbl[9] = '{16'h0010, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b0};
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.b_in      = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_diff", 32'(bus.diff), 32'(0));
        chk("rst_b_out", 32'(bus.b_out), 32'(0));
`ifdef SUB_OVF_EN
        chk("rst_ovf", 32'(bus.ovf), 32'(0));
`endif

        for (int i = 0; i < 10; i++) begin
            send(tbl[i], 1'b1);
            if (i == 0) begin
                lat = 1;
                while (!bus.out_valid && lat < 20) begin
                    tick();
                    lat++;
                end
                chk("latency", 32'(lat), 32'(5));
            end
            drain();
        end

        // backpressure: result held in DONE, operand pulses ignored
        bus.out_ready = 1'b0;
        send('{16'h4321, 16'h1111, 1'b1, 16'h320F, 1'b0, 1'b0}, 1'b1);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = k[0];
            bus.a        = 16'($urandom);
            bus.b        = 16'($urandom);
            tick();
            chk("bp_out_valid", 32'(bus.out_valid), 32'(1));
            chk("bp_in_ready", 32'(bus.in_ready), 32'(0));
            chk("bp_diff", 32'(bus.diff), 32'h320F);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_out_valid", 32'(bus.out_valid), 32'(0));
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'(1));
        chk("bp_sb_empty", 32'(sb.size()), 32'(0));

        // reset two cycles into RUN abandons the operation
        send('{16'h1111, 16'h2222, 1'b0, 16'h0000, 1'b0, 1'b0}, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_in_ready", 32'(bus.in_ready), 32'(1));
        chk("abort_out_valid", 32'(bus.out_valid), 32'(0));
        chk("abort_diff", 32'(bus.diff), 32'(0));
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (bus.out_valid) seen = 1'b1;
            tick();
        end
        chk("abort_no_valid", 32'(seen), 32'(0));
        send(tbl[4], 1'b1);
        drain();

        // back-to-back with in_valid held high
        accepts = 0;
        last = 0;
        lat = 0;
        bus.in_valid = 1'b1;
        while (accepts < 6 && lat < 100) begin
            if (bus.in_ready) begin
                v = model(16'($urandom), 16'($urandom), 1'($urandom));
                bus.a    = v.a;
                bus.b    = v.b;
                bus.b_in = v.bin;
                sb.push_back(v);
                if (accepts > 0) chk("b2b_interval", 32'(cyc - last), 32'(6));
                last = cyc;
                accepts++;
            end else begin
                bus.a    = 16'($urandom);
                bus.b    = 16'($urandom);
                bus.b_in = 1'($urandom);
            end
            tick();
            lat++;
        end
        bus.in_valid = 1'b0;
        chk("b2b_accepts", 32'(accepts), 32'(6));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
